// File: rtl/ctrl_pkg.sv
// Shared encodings for the Mini SRC control sequencer: state codes, opcodes,
// ALU codes, instruction classes and the per-state strobe decode.
package ctrl_pkg;

  localparam logic [3:0] ST_IDLE = 4'b0000;
  localparam logic [3:0] ST_T0   = 4'b0111;
  localparam logic [3:0] ST_T1   = 4'b1000;
  localparam logic [3:0] ST_T2   = 4'b1001;
  localparam logic [3:0] ST_T3   = 4'b1010;
  localparam logic [3:0] ST_T4   = 4'b1011;
  localparam logic [3:0] ST_T5   = 4'b1100;
  localparam logic [3:0] ST_T6   = 4'b1101;
  localparam logic [3:0] ST_T7   = 4'b1110;
  localparam logic [3:0] ST_HALT = 4'b1111;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE, S_T0 = ST_T0, S_T1 = ST_T1, S_T2 = ST_T2, S_T3 = ST_T3,
    S_T4 = ST_T4, S_T5 = ST_T5, S_T6 = ST_T6, S_T7 = ST_T7, S_HALT = ST_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  typedef enum logic [2:0] {
    CLS_ALU_REG, CLS_ALU_IMM, CLS_LD, CLS_ST, CLS_NOP, CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic mar_en;
    logic pc_inc;
    logic read;
    logic write;
    logic mdr_en;
    logic mdr_out;
    logic ir_en;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic y_en;
    logic c_out;
    logic z_en;
    logic zlo_out;
  } strobe_t;

  // Strobes active while sitting in state s for an instruction of class c.
  function automatic strobe_t strobes_for(input state_t s, input op_class_t c);
    strobe_t o;
    o = '0;
    case (s)
      S_T0: begin o.pc_out = 1'b1; o.mar_en = 1'b1; o.pc_inc = 1'b1; end
      S_T1: begin o.read = 1'b1; o.mdr_en = 1'b1; end
      S_T2: begin o.mdr_out = 1'b1; o.ir_en = 1'b1; end
      S_T3: begin o.grb = 1'b1; o.r_out = 1'b1; o.y_en = 1'b1; end
      S_T4: begin
        o.z_en = 1'b1;
        if (c == CLS_ALU_REG) begin o.grc = 1'b1; o.r_out = 1'b1; end
        else o.c_out = 1'b1;
      end
      S_T5: begin
        o.zlo_out = 1'b1;
        if (c == CLS_LD || c == CLS_ST) o.mar_en = 1'b1;
        else begin o.gra = 1'b1; o.r_in = 1'b1; end
      end
      S_T6: begin
        o.mdr_en = 1'b1;
        if (c == CLS_LD) o.read = 1'b1;
        else begin o.gra = 1'b1; o.r_out = 1'b1; end
      end
      S_T7: begin
        if (c == CLS_LD) begin o.mdr_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        else o.write = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into instruction class, ALU operation and legality.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5,
  parameter int ALU_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  output op_class_t        op_class,
  output logic [ALU_W-1:0] alu_code,
  output logic             legal
);

  always_comb begin
    op_class = CLS_NOP;
    alu_code = '0;
    legal    = 1'b1;
    case (opc)
      OPC_W'(OP_LD):   begin op_class = CLS_LD;      alu_code = ALU_W'(ALU_ADD); end
      OPC_W'(OP_ST):   begin op_class = CLS_ST;      alu_code = ALU_W'(ALU_ADD); end
      OPC_W'(OP_ADD):  begin op_class = CLS_ALU_REG; alu_code = ALU_W'(ALU_ADD); end
      OPC_W'(OP_SUB):  begin op_class = CLS_ALU_REG; alu_code = ALU_W'(ALU_SUB); end
      OPC_W'(OP_AND):  begin op_class = CLS_ALU_REG; alu_code = ALU_W'(ALU_AND); end
      OPC_W'(OP_OR):   begin op_class = CLS_ALU_REG; alu_code = ALU_W'(ALU_OR);  end
      OPC_W'(OP_ADDI): begin op_class = CLS_ALU_IMM; alu_code = ALU_W'(ALU_ADD); end
      OPC_W'(OP_ANDI): begin op_class = CLS_ALU_IMM; alu_code = ALU_W'(ALU_AND); end
      OPC_W'(OP_ORI):  begin op_class = CLS_ALU_IMM; alu_code = ALU_W'(ALU_OR);  end
      OPC_W'(OP_NOP):  op_class = CLS_NOP;
      OPC_W'(OP_HALT): op_class = CLS_HALT;
      default:         legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore control sequencer for the Mini SRC datapath: fetch T0-T2, class-dependent
// execute T3-T7, memory-ready stalls, run/halt control and illegal-opcode trap.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int IR_W    = 32,
  parameter int OPC_W   = 5,
  parameter int OPC_LSB = 27,
  parameter int ALU_W   = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [IR_W-1:0]  ir,
  input  logic             mem_ready,
  output logic             pc_out,
  output logic             mar_en,
  output logic             pc_inc,
  output logic             read,
  output logic             write,
  output logic             mdr_en,
  output logic             mdr_out,
  output logic             ir_en,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             r_in,
  output logic             r_out,
  output logic             y_en,
  output logic             c_out,
  output logic             z_en,
  output logic             zlo_out,
  output logic [ALU_W-1:0] alu_control,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state
);

  state_t           state_reg, state_next;
  logic [OPC_W-1:0] opc_reg, opc_live, dec_opc;
  op_class_t        dec_class;
  logic [ALU_W-1:0] dec_alu, alu_reg, alu_next;
  logic             dec_legal;
  logic             illegal_reg, illegal_next, halted_reg;
  strobe_t          strobe_reg, strobe_next;
  logic             unused_ir;

  assign opc_live  = ir[OPC_LSB +: OPC_W];
  assign unused_ir = ^ir;

  // The live opcode is only trusted in T2; afterwards the latched copy drives execute.
  assign dec_opc = (state_reg == S_T2) ? opc_live : opc_reg;

  ctrl_decode #(.OPC_W(OPC_W), .ALU_W(ALU_W)) u_decode (
    .opc      (dec_opc),
    .op_class (dec_class),
    .alu_code (dec_alu),
    .legal    (dec_legal)
  );

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      S_IDLE: if (run) state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1:   if (mem_ready) state_next = S_T2;
      S_T2: begin
        if (!dec_legal) begin
          state_next   = S_HALT;
          illegal_next = 1'b1;
        end else if (dec_class == CLS_NOP) state_next = S_T0;
        else if (dec_class == CLS_HALT)    state_next = S_HALT;
        else                               state_next = S_T3;
      end
      S_T3:   state_next = S_T4;
      S_T4:   state_next = S_T5;
      S_T5: begin
        if (dec_class == CLS_LD || dec_class == CLS_ST) state_next = S_T6;
        else state_next = run ? S_T0 : S_IDLE;
      end
      S_T6:   if (dec_class == CLS_ST || mem_ready) state_next = S_T7;
      S_T7:   if (dec_class == CLS_LD || mem_ready) state_next = run ? S_T0 : S_IDLE;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
    // Outputs are precomputed for the state being entered so they come straight off flops.
    strobe_next = strobes_for(state_next, dec_class);
    alu_next    = (state_next == S_T4) ? dec_alu : '0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg   <= S_IDLE;
      opc_reg     <= '0;
      strobe_reg  <= '0;
      alu_reg     <= '0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      if (state_reg == S_T2) opc_reg <= opc_live;
      strobe_reg  <= strobe_next;
      alu_reg     <= alu_next;
      halted_reg  <= (state_next == S_HALT);
      illegal_reg <= illegal_next;
    end
  end

  assign pc_out      = strobe_reg.pc_out;
  assign mar_en      = strobe_reg.mar_en;
  assign pc_inc      = strobe_reg.pc_inc;
  assign read        = strobe_reg.read;
  assign write       = strobe_reg.write;
  assign mdr_en      = strobe_reg.mdr_en;
  assign mdr_out     = strobe_reg.mdr_out;
  assign ir_en       = strobe_reg.ir_en;
  assign gra         = strobe_reg.gra;
  assign grb         = strobe_reg.grb;
  assign grc         = strobe_reg.grc;
  assign r_in        = strobe_reg.r_in;
  assign r_out       = strobe_reg.r_out;
  assign y_en        = strobe_reg.y_en;
  assign c_out       = strobe_reg.c_out;
  assign z_en        = strobe_reg.z_en;
  assign zlo_out     = strobe_reg.zlo_out;
  assign alu_control = alu_reg;
  assign halted      = halted_reg;
  assign illegal     = illegal_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench: opcode latency table, hand-written stall/halt/reset
// sequences, and random instruction streams against a cycle-schedule model.
module tb_ctrl_sequencer;

  localparam logic [3:0] ST_IDLE = 4'h0, ST_T0 = 4'h7, ST_T1 = 4'h8, ST_T2 = 4'h9,
                         ST_T3 = 4'hA, ST_T4 = 4'hB, ST_T5 = 4'hC, ST_T6 = 4'hD,
                         ST_T7 = 4'hE, ST_HALT = 4'hF;

  localparam logic [16:0] M_PC_OUT = 17'h10000, M_MAR_EN = 17'h08000, M_PC_INC = 17'h04000,
                          M_READ = 17'h02000, M_WRITE = 17'h01000, M_MDR_EN = 17'h00800,
                          M_MDR_OUT = 17'h00400, M_IR_EN = 17'h00200, M_GRA = 17'h00100,
                          M_GRB = 17'h00080, M_GRC = 17'h00040, M_R_IN = 17'h00020,
                          M_R_OUT = 17'h00010, M_Y_EN = 17'h00008, M_C_OUT = 17'h00004,
                          M_Z_EN = 17'h00002, M_ZLO_OUT = 17'h00001;

  localparam int K_REG = 0, K_IMM = 1, K_LD = 2, K_ST = 3, K_NOP = 4, K_HALT = 5, K_BAD = 6;

  logic clk, clr, run, mem_ready;
  logic [31:0] ir;
  logic pc_out, mar_en, pc_inc, read, write, mdr_en, mdr_out, ir_en;
  logic gra, grb, grc, r_in, r_out, y_en, c_out, z_en, zlo_out;
  logic [4:0] alu_control;
  logic halted, illegal;
  logic [3:0] state;

  ctrl_sequencer #(.IR_W(32), .OPC_W(5), .OPC_LSB(27), .ALU_W(5)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_en(mar_en), .pc_inc(pc_inc), .read(read), .write(write),
    .mdr_en(mdr_en), .mdr_out(mdr_out), .ir_en(ir_en), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .y_en(y_en), .c_out(c_out), .z_en(z_en),
    .zlo_out(zlo_out), .alu_control(alu_control), .halted(halted), .illegal(illegal),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [27:0] exp;
    logic        mr;
    logic        rn;
    logic [31:0] irv;
    int          ino;
    int          cyc;
  } step_t;
  step_t sched[$];
  bit at_idle;
  int ino = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0] op;
    int         cycles;
    logic [8:0] t4;   // {alu_control, c_out, grc, r_out, z_en} seen in T4
  } vec_t;
  vec_t vt[10];

  logic [4:0] ops[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] obs();
    return {state, pc_out, mar_en, pc_inc, read, write, mdr_en, mdr_out, ir_en, gra, grb,
            grc, r_in, r_out, y_en, c_out, z_en, zlo_out, alu_control, halted, illegal};
  endfunction

  function automatic logic [27:0] mk(input logic [3:0] st, input logic [16:0] sb,
                                     input logic [4:0] alu, input logic h, input logic il);
    return {st, sb, alu, h, il};
  endfunction

  function automatic int kind(input logic [4:0] op);
    case (op)
      5'b00000: return K_LD;
      5'b00010: return K_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110: return K_REG;
      5'b01100, 5'b01101, 5'b01110: return K_IMM;
      5'b11010: return K_NOP;
      5'b11011: return K_HALT;
      default:  return K_BAD;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00010, 5'b00011, 5'b01100: return 5'b00011;
      5'b00100: return 5'b00100;
      5'b00101, 5'b01101: return 5'b00101;
      5'b00110, 5'b01110: return 5'b00110;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input logic [27:0] e, input logic m, input logic r, input logic [31:0] v);
    sched.push_back('{exp: e, mr: m, rn: r, irv: v, ino: ino, cyc: cyc});
    cyc++;
  endtask

  // Expected per-cycle schedule for one instruction, built from the state/strobe table.
  task automatic gen_instr(input logic [4:0] op, input int w1, input int w6, input int w7,
                           input bit end_run, input int idle_wait);
    logic [31:0] irv, rir;
    logic [16:0] t4s;
    int k;
    irv = {op, 27'($urandom)};
    rir = $urandom;
    k   = kind(op);
    ino++;
    cyc = 0;
    if (at_idle) begin
      for (int i = 0; i < idle_wait; i++) push(mk(ST_IDLE, '0, '0, 0, 0), rb(), 1'b0, irv);
      push(mk(ST_IDLE, '0, '0, 0, 0), rb(), 1'b1, irv);
    end
    at_idle = 1'b0;
    push(mk(ST_T0, M_PC_OUT | M_MAR_EN | M_PC_INC, '0, 0, 0), rb(), rb(), irv);
    for (int i = 0; i < w1; i++) push(mk(ST_T1, M_READ | M_MDR_EN, '0, 0, 0), 1'b0, rb(), irv);
    push(mk(ST_T1, M_READ | M_MDR_EN, '0, 0, 0), 1'b1, rb(), irv);
    push(mk(ST_T2, M_MDR_OUT | M_IR_EN, '0, 0, 0), rb(), (k == K_NOP) ? 1'b1 : rb(), irv);
    if (k == K_NOP) return;
    if (k == K_HALT || k == K_BAD) begin
      for (int i = 0; i < 3; i++) push(mk(ST_HALT, '0, '0, 1'b1, k == K_BAD), rb(), rb(), rir);
      return;
    end
    push(mk(ST_T3, M_GRB | M_R_OUT | M_Y_EN, '0, 0, 0), rb(), rb(), rir);
    t4s = M_Z_EN | ((k == K_REG) ? (M_GRC | M_R_OUT) : M_C_OUT);
    push(mk(ST_T4, t4s, alu_of(op), 0, 0), rb(), rb(), rir);
    if (k == K_REG || k == K_IMM) begin
      push(mk(ST_T5, M_ZLO_OUT | M_GRA | M_R_IN, '0, 0, 0), rb(), end_run, rir);
    end else begin
      push(mk(ST_T5, M_ZLO_OUT | M_MAR_EN, '0, 0, 0), rb(), rb(), rir);
      if (k == K_LD) begin
        for (int i = 0; i < w6; i++) push(mk(ST_T6, M_READ | M_MDR_EN, '0, 0, 0), 1'b0, rb(), rir);
        push(mk(ST_T6, M_READ | M_MDR_EN, '0, 0, 0), 1'b1, rb(), rir);
        push(mk(ST_T7, M_MDR_OUT | M_GRA | M_R_IN, '0, 0, 0), rb(), end_run, rir);
      end else begin
        push(mk(ST_T6, M_GRA | M_R_OUT | M_MDR_EN, '0, 0, 0), rb(), rb(), rir);
        for (int i = 0; i < w7; i++) push(mk(ST_T7, M_WRITE, '0, 0, 0), 1'b0, rb(), rir);
        push(mk(ST_T7, M_WRITE, '0, 0, 0), 1'b1, end_run, rir);
      end
    end
    at_idle = !end_run;
  endtask

  task automatic play();
    step_t s;
    while (sched.size() > 0) begin
      s = sched.pop_front();
      @(negedge clk);
      chk($sformatf("instr%0d_cyc%0d", s.ino, s.cyc), obs(), s.exp);
      mem_ready = s.mr;
      run       = s.rn;
      ir        = s.irv;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0; run = 1'b0; mem_ready = 1'b0;
    #1 chk("reset_async", obs(), 28'd0);
    @(negedge clk);
    chk("reset_hold", obs(), 28'd0);
    clr = 1'b1;
    at_idle = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [8:0] t4cap;
    logic [4:0] op;
    int w1, w6, w7, iw;
    bit er;

    vt[0] = '{5'b00000, 8, 9'b00011_1001};
    vt[1] = '{5'b00010, 8, 9'b00011_1001};
    vt[2] = '{5'b00011, 6, 9'b00011_0111};
    vt[3] = '{5'b00100, 6, 9'b00100_0111};
    vt[4] = '{5'b00101, 6, 9'b00101_0111};
    vt[5] = '{5'b00110, 6, 9'b00110_0111};
    vt[6] = '{5'b01100, 6, 9'b00011_1001};
    vt[7] = '{5'b01101, 6, 9'b00101_1001};
    vt[8] = '{5'b01110, 6, 9'b00110_1001};
    vt[9] = '{5'b11010, 3, 9'b00000_0000};
    for (int i = 0; i < 10; i++) ops[i] = vt[i].op;

    clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0; at_idle = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", obs(), 28'd0);
    clr = 1'b1;

    // Opcode table with mem_ready tied high: instruction length and T4 strobes.
    run = 1'b1; mem_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      ir = {vt[r].op, 27'($urandom)};
      for (int i = 0; i < 10 && state != ST_T0; i++) @(negedge clk);
      chk($sformatf("tbl%0d_start", r), state, ST_T0);
      cnt = 0; t4cap = '0;
      do begin
        if (state == ST_T4) t4cap = {alu_control, c_out, grc, r_out, z_en};
        cnt++;
        @(negedge clk);
      end while (state != ST_T0 && cnt < 20);
      chk($sformatf("tbl_op%b_cycles", vt[r].op), cnt, vt[r].cycles);
      chk($sformatf("tbl_op%b_t4", vt[r].op), t4cap, vt[r].t4);
      $display("table op=%b cycles=%0d t4=%b", vt[r].op, cnt, t4cap);
    end

    // andi, add with 3 T1 stalls, st with 2 T7 stalls, ld ending in IDLE.
    do_reset();
    gen_instr(5'b01101, 0, 0, 0, 1'b1, 0);
    gen_instr(5'b00011, 3, 0, 0, 1'b1, 0);
    gen_instr(5'b00010, 0, 0, 2, 1'b1, 0);
    gen_instr(5'b00000, 0, 0, 0, 1'b0, 0);
    gen_instr(5'b00000, 1, 2, 0, 1'b1, 1);
    play();
    $display("directed stall sequence done");

    // Illegal opcode traps; run toggling cannot leave HALT; clr clears it.
    do_reset();
    gen_instr(5'b10101, 0, 0, 0, 1'b1, 0);
    play();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = ~run;
      chk("illegal_hold", obs(), mk(ST_HALT, '0, '0, 1'b1, 1'b1));
    end
    @(negedge clk);
    run = 1'b0;
    clr = 1'b0;
    #1 chk("illegal_clr", obs(), 28'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("illegal_after_clr", obs(), 28'd0);
    $display("illegal trap sequence done");

    // Asynchronous clear landing mid-T4, between clock edges.
    do_reset();
    run = 1'b1; mem_ready = 1'b1; ir = {5'b00011, 27'd0};
    for (int i = 0; i < 15 && state != ST_T4; i++) @(negedge clk);
    chk("clr_reach_t4", state, ST_T4);
    #2 clr = 1'b0;
    #1 chk("clr_mid_t4", obs(), 28'd0);
    run = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clr_stay_idle", obs(), 28'd0);
    end
    $display("mid-instruction clear sequence done");

    // Random instruction stream.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 9)];
      w1 = $urandom_range(0, 3);
      w6 = $urandom_range(0, 3);
      w7 = $urandom_range(0, 3);
      er = ($urandom_range(0, 3) != 0);
      iw = $urandom_range(0, 2);
      gen_instr(op, w1, w6, w7, er, iw);
      $display("random instr %0d op=%b w1=%0d w6=%0d w7=%0d end_run=%0d", n, op, w1, w6, w7, er);
      play();
    end
    gen_instr(5'b11011, 1, 0, 0, 1'b1, 0);
    play();
    $display("halt instruction done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised Moore-style control sequencer for the Mini SRC datapath. It replaces hand-driven T0..T6 testbench stimulus with hardware-generated control strobes. Per instruction it runs the fetch cycles (T0–T2), then an opcode-dependent execute sequence, and returns to fetch. It adds what hand-driven stimulus lacks: multiple instruction classes, a memory-ready stall handshake, run/halt control and illegal-opcode trapping.

## Interface
Parameters:
- IR_W, 32, instruction register width
- OPC_W, 5, opcode field width
- OPC_LSB, 27, LSB position of the opcode field in ir (field is ir[OPC_LSB+OPC_W-1:OPC_LSB])
- ALU_W, 5, alu_control width

Ports:
- clk  in  1  system clock, all state changes on rising edge
- clr  in  1  asynchronous, active-low reset
- run  in  1  level; allows leaving IDLE
- ir  in  IR_W  current instruction register contents
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_out, mar_en, pc_inc, read, write, mdr_en, mdr_out, ir_en  out  1 each  fetch/memory strobes
- gra, grb, grc, r_in, r_out  out  1 each  register-select strobes
- y_en, c_out, z_en, zlo_out  out  1 each  ALU-path strobes
- alu_control  out  ALU_W  ALU operation code
- halted  out  1  sequencer is in HALT
- illegal  out  1  HALT was entered via an undefined opcode
- state  out  4  current state encoding, for debug

## Operation
- Outputs are decoded from the state register and opcode only. No input feeds an output combinationally, except mem_ready, which has no output path at all.
- Opcodes and their execute behaviour:
  - ld 00000
  - st 00010
  - add 00011, sub 00100, and 00101, or 00110: R[ra] ← R[rb] op R[rc]
  - addi 01100, andi 01101, ori 01110: R[ra] ← R[rb] op C
  - nop 11010
  - halt 11011
  - any other opcode is illegal.
- alu_control values:
  - add/addi/ld/st: 00011
  - sub: 00100
  - and/andi: 00101
  - or/ori: 00110
  - 00000 in every non-ALU state.
- States and their asserted strobes:
  - IDLE: no strobes. Goes to T0 when run=1.
  - T0: pc_out, mar_en, pc_inc. Goes to T1.
  - T1: read, mdr_en. Holds until mem_ready=1, then goes to T2.
  - T2: mdr_out, ir_en. Goes to T3. nop returns to T0, halt goes to HALT, illegal goes to HALT with illegal set.
  - T3: grb, r_out, y_en.
  - T4: z_en, alu_control, plus c_out (imm, ld, st) or grc + r_out (reg ops).
  - T5 for ALU ops: zlo_out, gra, r_in. Then T0 if run=1, otherwise IDLE.
  - T5 for ld/st: zlo_out, mar_en.
  - T6 for ld: read, mdr_en. Holds until mem_ready=1.
  - T6 for st: gra, r_out, mdr_en.
  - T7 for ld: mdr_out, gra, r_in.
  - T7 for st: write. Holds until mem_ready=1.
  - After ld/st T7: T0 if run=1, otherwise IDLE.
  - HALT: halted=1. Stays in HALT until reset.
- The opcode is sampled from ir in T2 and latched internally; later ir changes do not alter the execute sequence.
- run is only checked in IDLE and at instruction end. An instruction in progress always completes.

## Timing
- Reset: clr low asynchronously forces IDLE, all outputs 0, illegal=0, latched opcode 0. Reset mid-instruction abandons the instruction with no further strobes.
- Latency with mem_ready tied high:
  - ALU instruction: 6 cycles (T0–T5).
  - ld/st: 8 cycles.
  - nop: 3 cycles.
- Each cycle mem_ready stays low in T1, ld-T6 or st-T7 adds one cycle; the strobes of that state stay asserted for the whole wait.
- mem_ready has no effect outside the three wait states.
- A strobe never changes except on a clock edge or on reset assertion.

## Structure
- Shared package ctrl_pkg holds:
  - the state encoding localparams (IDLE=0000, T0–T7=0111–1110, HALT=1111)
  - the opcode constants
  - the ALU code constants.
- One sub-module, ctrl_decode: combinational opcode → {class, alu_code, legal}. Class is one of alu_reg, alu_imm, ld, st, nop, halt.

## Test plan
- andi (ir[31:27]=01101), run=1, mem_ready=1 → states T0..T5 in 6 cycles; T4: alu_control=00101 with c_out, z_en; T5: zlo_out, gra, r_in; next state T0.
- add with mem_ready low 3 cycles in T1 → T1 lasts 4 cycles with read and mdr_en held; instruction total is 9 cycles; T4: grc, r_out.
- st with mem_ready low 2 cycles in T7 → write held 3 cycles, then T0. ld → T7: mdr_out, gra, r_in, total 8 cycles.
- Opcode 10101 → HALT after T2, halted=1, illegal=1; run toggling leaves it in HALT; clr low returns to IDLE with all outputs 0.
- clr asserted during T4 between clock edges → outputs 0 immediately, state=0000; after release with run=0, stays IDLE.
